multiplikation_schaltwerk: RTL

Sequential shift-add multiplier, 32×32 → 64 bit, unsigned or two's-complement signed, one multiplier bit per clock. It is the multiply counterpart to the team's sequential divider and shares its start-pulse operand capture. It adds an explicit busy/done handshake so the surrounding datapath can sequence back-to-back operations.

---
 rtl/multiplikation_schaltwerk.sv | 87 ++++++++
 1 files changed

// File: rtl/multiplikation_schaltwerk.sv
// Sequential shift-add multiplier: 32x32 -> 64 bit, unsigned or two's-complement,
// one multiplier bit per clock with a busy/done handshake and a fixed 32-cycle latency.
module multiplikation_schaltwerk (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic        neg_q;
  logic [63:0] acc_q;
  logic [63:0] acc_d;
  logic [63:0] p_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  // Signed operands are multiplied as magnitudes; 0x80000000 stays 0x80000000.
  always_comb begin
    a_mag = (sign && a[31]) ? (~a + 32'd1) : a;
    b_mag = (sign && b[31]) ? (~b + 32'd1) : b;
    acc_d = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block sees the pre-edge values of its peers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      neg_q    <= 1'b0;
      acc_q    <= 64'd0;
      p_q      <= 64'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= {32'd0, a_mag};
            mplier_q <= b_mag;
            neg_q    <= sign & (a[31] ^ b[31]);
            acc_q    <= 64'd0;
            cnt_q    <= 5'd0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          // Shift the multiplicand up and the multiplier down instead of
          // indexing by cnt; the partial products are the same.
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            p_q     <= neg_q ? (~acc_d + 64'd1) : acc_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p    = p_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
